// File: rtl/arbitro_memoria_datos.sv
// Two-port arbiter/sequencer for the BIP data memory: one issue stage feeding the negedge RAM,
// one completion stage returning ack/rdata. Define MEMDAT_ARB_RR_EN for round-robin, else port 0 has priority.
module arbitro_memoria_datos #(
  parameter int RAM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0,
  input  logic                  i_req1,
  input  logic                  i_we0,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [RAM_WIDTH-1:0]  i_wdata0,
  input  logic [RAM_WIDTH-1:0]  i_wdata1,
  output logic                  o_ack0,
  output logic                  o_ack1,
  output logic [RAM_WIDTH-1:0]  o_rdata0,
  output logic [RAM_WIDTH-1:0]  o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [RAM_WIDTH-1:0]  o_mem_data,
  output logic                  o_mem_we,
  input  logic [RAM_WIDTH-1:0]  i_mem_data,
  output logic                  o_busy
);
  // Handshake: a requester holds req/we/addr/wdata stable until it samples ack = 1. ack is a
  // one-cycle pulse on the edge after issue; an in-flight port is masked, so a req still high
  // on its ack edge is not issued again.

  logic [1:0]            infl_q, infl_d;
  logic                  win_q, win_d;
  logic [1:0]            ack_q, ack_d;
  logic [RAM_WIDTH-1:0]  rdata0_q, rdata0_d;
  logic [RAM_WIDTH-1:0]  rdata1_q, rdata1_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [RAM_WIDTH-1:0]  mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic [1:0]            elig;
  logic                  sel;
`ifdef MEMDAT_ARB_RR_EN
  logic                  rr_q, rr_d;
`endif

  assign elig = {i_req1, i_req0} & ~infl_q;

  always_comb begin
`ifdef MEMDAT_ARB_RR_EN
    sel  = (elig == 2'b11) ? rr_q : elig[1];
    rr_d = (elig != 2'b00) ? ~sel : rr_q;
`else
    sel  = ~elig[0];
`endif
  end

  always_comb begin
    infl_d     = infl_q;
    win_d      = win_q;
    ack_d      = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;

    // Completion of the access issued on the previous edge.
    if (infl_q[win_q]) begin
      ack_d[win_q]  = 1'b1;
      infl_d[win_q] = 1'b0;
      if (!mem_we_q) begin
        if (win_q) rdata1_d = i_mem_data;
        else       rdata0_d = i_mem_data;
      end
    end

    if (elig != 2'b00) begin
      mem_addr_d   = sel ? i_addr1  : i_addr0;
      mem_data_d   = sel ? i_wdata1 : i_wdata0;
      mem_we_d     = sel ? i_we1    : i_we0;
      infl_d[sel]  = 1'b1;
      win_d        = sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      infl_q     <= 2'b00;
      win_q      <= 1'b0;
      ack_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
`ifdef MEMDAT_ARB_RR_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      infl_q     <= infl_d;
      win_q      <= win_d;
      ack_q      <= ack_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
`ifdef MEMDAT_ARB_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign o_ack0     = ack_q[0];
  assign o_ack1     = ack_q[1];
  assign o_rdata0   = rdata0_q;
  assign o_rdata1   = rdata1_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_we   = mem_we_q;
  assign o_busy     = |infl_q;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: negedge RAM model, shadow memory, directed steps plus
// randomized two-port traffic checked for latency bounds, ack pattern and read data.
module tb_arbitro_memoria_datos;
  logic        i_clk, i_rst_n;
  logic        i_req0, i_req1, i_we0, i_we1;
  logic [9:0]  i_addr0, i_addr1;
  logic [15:0] i_wdata0, i_wdata1;
  logic        o_ack0, o_ack1;
  logic [15:0] o_rdata0, o_rdata1;
  logic [9:0]  o_mem_addr;
  logic [15:0] o_mem_data;
  logic        o_mem_we;
  logic [15:0] i_mem_data;
  logic        o_busy;

  int checks = 0;
  int failures = 0;
  int last_win = 0;

  logic [15:0] ref_mem [1024];
  logic        act [2];
  int          age [2];
  logic        cwe [2];
  logic [9:0]  caddr [2];
  logic [15:0] cdat [2];

  arbitro_memoria_datos dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_ack0(o_ack0), .o_ack1(o_ack1), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_we(o_mem_we),
    .i_mem_data(i_mem_data), .o_busy(o_busy)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // negedge data memory, preloaded with index values
  logic [15:0] mem [1024];
  logic [15:0] mem_q;
  bit          preload_done;
  always @(negedge i_clk) begin
    if (!preload_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'(i);
      preload_done <= 1'b1;
    end else if (o_mem_we) mem[o_mem_addr] <= o_mem_data;
    else mem_q <= mem[o_mem_addr];
  end
  assign i_mem_data = mem_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [9:0] a, input logic [15:0] d);
    i_req0 = r; i_we0 = w; i_addr0 = a; i_wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [9:0] a, input logic [15:0] d);
    i_req1 = r; i_we1 = w; i_addr1 = a; i_wdata1 = d;
  endtask

  // one uncontended access on port p
  task automatic single(input int p, input logic w, input logic [9:0] a, input logic [15:0] d);
    if (p == 0) set0(1'b1, w, a, d); else set1(1'b1, w, a, d);
    tick();
    check("single_issue_addr", o_mem_addr, a);
    check("single_issue_we", o_mem_we, w);
    check("single_busy", o_busy, 1);
    check("single_no_early_ack", {o_ack1, o_ack0}, 0);
    tick();
    check("single_ack", {o_ack1, o_ack0}, (p == 0) ? 1 : 2);
    check("single_no_reissue", o_mem_we, 0);
    check("single_busy_clear", o_busy, 0);
    if (w) ref_mem[a] = d;
    else check("single_rdata", (p == 0) ? o_rdata0 : o_rdata1, ref_mem[a]);
    if (p == 0) set0(1'b0, 1'b0, a, 16'h0); else set1(1'b0, 1'b0, a, 16'h0);
    last_win = p;
  endtask

  // both ports read in the same cycle
  task automatic contention(input logic [9:0] a0, input logic [9:0] a1);
    int first;
`ifdef MEMDAT_ARB_RR_EN
    first = (last_win == 0) ? 1 : 0;
`else
    first = 0;
`endif
    set0(1'b1, 1'b0, a0, 16'h0);
    set1(1'b1, 1'b0, a1, 16'h0);
    tick();
    check("cont_issue_no_ack", {o_ack1, o_ack0}, 0);
    check("cont_issue_addr", o_mem_addr, (first == 0) ? a0 : a1);
    tick();
    check("cont_first_ack", {o_ack1, o_ack0}, (first == 0) ? 1 : 2);
    check("cont_first_rdata", (first == 0) ? o_rdata0 : o_rdata1,
          (first == 0) ? ref_mem[a0] : ref_mem[a1]);
    check("cont_second_issue_addr", o_mem_addr, (first == 0) ? a1 : a0);
    if (first == 0) set0(1'b0, 1'b0, a0, 16'h0); else set1(1'b0, 1'b0, a1, 16'h0);
    tick();
    check("cont_second_ack", {o_ack1, o_ack0}, (first == 0) ? 2 : 1);
    check("cont_second_rdata", (first == 0) ? o_rdata1 : o_rdata0,
          (first == 0) ? ref_mem[a1] : ref_mem[a0]);
    set0(1'b0, 1'b0, a0, 16'h0);
    set1(1'b0, 1'b0, a1, 16'h0);
    last_win = (first == 0) ? 1 : 0;
  endtask

  task automatic drive_port(input int p);
    if (p == 0) set0(act[0], cwe[0], caddr[0], cdat[0]);
    else        set1(act[1], cwe[1], caddr[1], cdat[1]);
  endtask

  // Each port owns half the address space, so the shadow memory is order-independent across ports.
  task automatic run_traffic(input int n, input int pct, input bit sus);
    logic [1:0] a;
    int other;
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && ($urandom_range(99) < pct)) begin
          act[p]   = 1'b1;
          age[p]   = 0;
          cwe[p]   = 1'($urandom_range(1));
          caddr[p] = {p[0], 9'($urandom_range(511))};
          cdat[p]  = 16'($urandom);
        end
        drive_port(p);
      end
      tick();
      a = {o_ack1, o_ack0};
      if (sus && i > 0) begin
        check("sus_one_ack", {1'b0, a[0] ^ a[1]}, 1);
        other = a[0] ? 1 : 0;
        check("sus_mem_addr", o_mem_addr, caddr[other]);
        check("sus_mem_we", o_mem_we, cwe[other]);
      end
      for (int p = 0; p < 2; p++) begin
        if (!act[p]) check("trf_idle_ack", a[p], 0);
        else begin
          age[p]++;
          if (a[p] || age[p] >= 3) begin
            check("trf_ack_within_2", a[p], 1);
`ifndef MEMDAT_ARB_RR_EN
            if (p == 0) check("trf_p0_latency", age[p], 2);
`endif
            if (!cwe[p]) check("trf_rdata", (p == 0) ? o_rdata0 : o_rdata1, ref_mem[caddr[p]]);
            else ref_mem[caddr[p]] = cdat[p];
            act[p] = 1'b0;
          end
        end
      end
    end
    for (int p = 0; p < 2; p++) drive_port(p);
  endtask

  initial begin
    logic [15:0] old_val;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'(i);
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; age[p] = 0; cwe[p] = 1'b0; caddr[p] = '0; cdat[p] = '0;
    end
    set0(1'b0, 1'b0, 10'h0, 16'h0);
    set1(1'b0, 1'b0, 10'h0, 16'h0);
    i_rst_n = 1'b0;

    // reset held 3 cycles, req0 asserted mid-reset
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 1) set0(1'b1, 1'b1, 10'h005, 16'hBEEF);
      check("rst_mem_we", o_mem_we, 0);
      check("rst_acks", {o_ack1, o_ack0}, 0);
      check("rst_busy", o_busy, 0);
      check("rst_mem_addr", o_mem_addr, 0);
      check("rst_mem_data", o_mem_data, 0);
      check("rst_rdata", {o_rdata1, o_rdata0}, 0);
    end
    set0(1'b0, 1'b0, 10'h0, 16'h0);
    i_rst_n = 1'b1;
    tick();
    check("post_rst_idle_we", o_mem_we, 0);

    // write then read on port 0, read data held afterwards
    single(0, 1'b1, 10'h005, 16'hBEEF);
    single(0, 1'b0, 10'h005, 16'h0);
    tick();
    check("rdata0_held", o_rdata0, 16'hBEEF);
    check("held_no_ack", {o_ack1, o_ack0}, 0);

    // contention, a port 1 access to move the pointer, then contention again
    contention(10'h010, 10'h011);
    single(1, 1'b0, 10'h200, 16'h0);
    contention(10'h012, 10'h013);

    // cross-port coherence: port 1 writes at N, port 0 reads same word at N+1
    set1(1'b1, 1'b1, 10'h3FF, 16'h1234);
    tick();
    set0(1'b1, 1'b0, 10'h3FF, 16'h0);
    tick();
    check("coh_ack1", {o_ack1, o_ack0}, 2);
    set1(1'b0, 1'b0, 10'h0, 16'h0);
    ref_mem[10'h3FF] = 16'h1234;
    tick();
    check("coh_ack0", {o_ack1, o_ack0}, 1);
    check("coh_rdata0", o_rdata0, 16'h1234);
    set0(1'b0, 1'b0, 10'h0, 16'h0);
    tick();

    // sustained load, then random traffic, then drain
    run_traffic(40, 100, 1'b1);
    run_traffic(4, 0, 1'b0);
    run_traffic(300, 50, 1'b0);
    run_traffic(4, 0, 1'b0);

    // reset between the issue posedge and the write negedge drops the write
    old_val = ref_mem[10'h020];
    set0(1'b1, 1'b1, 10'h020, ~old_val);
    tick();
    check("inflight_we_issued", o_mem_we, 1);
    i_rst_n = 1'b0;
    #1;
    check("inflight_we_cleared", o_mem_we, 0);
    check("inflight_busy_cleared", o_busy, 0);
    set0(1'b0, 1'b0, 10'h0, 16'h0);
    tick();
    check("inflight_no_ack", {o_ack1, o_ack0}, 0);
    i_rst_n = 1'b1;
    tick();
    single(0, 1'b0, 10'h020, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
